// File: rtl/settable_clock_rpt.sv
// HH:MM:SS clock with a set FSM (RUN/SET_H/SET_M/SET_S), auto-repeat up/down,
// edit-field blink and a 12/24-hour display; drives six active-low 7-segment digits.
//
// state | meaning
// RUN   | time advances on each prescaler terminal count
// SET_H | hours edited, time frozen
// SET_M | minutes edited, time frozen
// SET_S | seconds edited, time frozen
module settable_clock_rpt #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int BLINK_DIV    = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic       up,
  input  logic       down,
  input  logic       mode12,
  output logic [6:0] disp0,
  output logic [6:0] disp1,
  output logic [6:0] disp2,
  output logic [6:0] disp3,
  output logic [6:0] disp4,
  output logic [6:0] disp5,
  output logic       pm,
  output logic [1:0] state,
  output logic       tick
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_TC     = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RPT_DELAY_LD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RATE_LD  = RW'(REPEAT_RATE - 1);
  localparam logic [BW-1:0] BLINK_LD     = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  state_t          st;
  logic [4:0]      hour;
  logic [5:0]      minute;
  logic [5:0]      second;
  logic [PW-1:0]   presc;
  logic [RW-1:0]   rpt_cnt;
  logic [RW-1:0]   rpt_nxt;
  logic [BW-1:0]   blink_cnt;
  logic            blink_hide;
  logic            set_q, up_q, down_q;
  logic            set_rise;
  logic            step_req;
  logic [5:0]      hour_step, minute_step, second_step;
  logic [5:0]      hour_disp;
  logic [7:0]      hour_bcd, minute_bcd, second_bcd;
  logic [6:0]      seg [6];

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max_v,
                                           input logic inc);
    if (inc) return (v == max_v) ? 6'd0 : v + 6'd1;
    else     return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

  function automatic logic [7:0] bcd2(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    t = 4'd0;
    r = v;
    for (int i = 0; i < 5; i++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign set_rise = set & ~set_q;
  assign tick     = (st == RUN) && (presc == PRESC_TC);
  assign state    = st;
  assign pm       = (hour >= 5'd12);

  assign hour_step   = wrap_step({1'b0, hour}, 6'd23, up);
  assign minute_step = wrap_step(minute, 6'd59, up);
  assign second_step = wrap_step(second, 6'd59, up);

  // Repeat timer is a down-counter: reload on each step, step again when it hits zero.
  always_comb begin
    step_req = 1'b0;
    rpt_nxt  = '0;
    if (st != RUN && !set_rise && (up ^ down)) begin
      if ((up & ~up_q) | (down & ~down_q)) begin
        step_req = 1'b1;
        rpt_nxt  = RPT_DELAY_LD;
      end else if (rpt_cnt == '0) begin
        step_req = 1'b1;
        rpt_nxt  = RPT_RATE_LD;
      end else begin
        rpt_nxt = rpt_cnt - RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= RUN;
      hour       <= '0;
      minute     <= '0;
      second     <= '0;
      presc      <= '0;
      rpt_cnt    <= '0;
      blink_cnt  <= '0;
      blink_hide <= 1'b0;
      set_q      <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      set_q   <= set;
      up_q    <= up;
      down_q  <= down;
      rpt_cnt <= rpt_nxt;

      if (tick) begin
        presc <= '0;
        if (second == 6'd59) begin
          second <= '0;
          if (minute == 6'd59) begin
            minute <= '0;
            hour   <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
          end else begin
            minute <= minute + 6'd1;
          end
        end else begin
          second <= second + 6'd1;
        end
      end else if (st == RUN && !set_rise) begin
        presc <= presc + PW'(1);
      end else begin
        presc <= '0;
      end

      if (step_req) begin
        case (st)
          SET_H:   hour   <= hour_step[4:0];
          SET_M:   minute <= minute_step;
          SET_S:   second <= second_step;
          default: ;
        endcase
      end

      if (set_rise) begin
        st         <= state_t'(st + 2'd1);
        blink_cnt  <= BLINK_LD;
        blink_hide <= 1'b0;
      end else if (blink_cnt == '0) begin
        blink_cnt  <= BLINK_LD;
        blink_hide <= ~blink_hide;
      end else begin
        blink_cnt <= blink_cnt - BW'(1);
      end
    end
  end

  always_comb begin
    hour_disp = {1'b0, hour};
    if (mode12) begin
      if (hour == 5'd0)       hour_disp = 6'd12;
      else if (hour > 5'd12)  hour_disp = {1'b0, hour} - 6'd12;
    end
  end

  assign hour_bcd   = bcd2(hour_disp);
  assign minute_bcd = bcd2(minute);
  assign second_bcd = bcd2(second);

  // Displays are forced to "0" while reset is held so 12-hour mode cannot show 12 then.
  always_comb begin
    seg[0] = seg7(second_bcd[3:0]);
    seg[1] = seg7(second_bcd[7:4]);
    seg[2] = seg7(minute_bcd[3:0]);
    seg[3] = seg7(minute_bcd[7:4]);
    seg[4] = seg7(hour_bcd[3:0]);
    seg[5] = seg7(hour_bcd[7:4]);
    if (blink_hide) begin
      case (st)
        SET_H: begin seg[4] = 7'h7F; seg[5] = 7'h7F; end
        SET_M: begin seg[2] = 7'h7F; seg[3] = 7'h7F; end
        SET_S: begin seg[0] = 7'h7F; seg[1] = 7'h7F; end
        default: ;
      endcase
    end
    if (!reset) begin
      for (int i = 0; i < 6; i++) seg[i] = 7'b1000000;
    end
  end

  assign disp0 = seg[0];
  assign disp1 = seg[1];
  assign disp2 = seg[2];
  assign disp3 = seg[3];
  assign disp4 = seg[4];
  assign disp5 = seg[5];

endmodule

// File: doc/settable_clock_rpt.md
Name: settable_clock_rpt

Overview:
- Parametrised successor to the team's simple HH:MM:SS clock. Keeps time from a prescaled system clock and drives six 7-segment digits.
- Adds a seconds-setting state and auto-repeat on held up/down buttons.
- Adds blinking of the field being edited and a 12/24-hour display mode with a PM flag.
- Sits between the debounced/synchronised board buttons and the display pins.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per one-second tick (>=2).
- REPEAT_DELAY, 25_000_000, cycles a button must be held before auto-repeat starts (>=1).
- REPEAT_RATE, 5_000_000, cycles between auto-repeat steps (>=1).
- BLINK_DIV, 25_000_000, half-period of the edit-field blink in cycles (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- set  input  1  synchronised level; rising edge advances the set FSM.
- up  input  1  synchronised level; increments the selected field.
- down  input  1  synchronised level; decrements the selected field.
- mode12  input  1  1 = 12-hour display, 0 = 24-hour display.
- disp0..disp5  output  7 each  segments, active-low, bit0=a .. bit6=g. Digit order: disp0/disp1 = sec ones/tens, disp2/disp3 = min ones/tens, disp4/disp5 = hour ones/tens.
- pm  output  1  1 when internal hour >= 12. Valid in both display modes.
- state  output  2  0=RUN, 1=SET_H, 2=SET_M, 3=SET_S.
- tick  output  1  one-cycle pulse on each prescaler terminal count.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - hours, minutes, seconds, prescaler, repeat counter, blink counter, all edge registers;
  - state to RUN, tick to 0, pm to 0.
  - Displays show 00 00 00: every digit is 7'b1000000 (active-low "0") in both modes.
  - In 12-hour mode, internal hour 0 displays as 12; this applies from the first clock after reset release, when displays are combinational from registers.
- Internal time is always 24 h: hours 0..23, minutes 0..59, seconds 0..59. Widths are 5/6/6 bits.
- RUN state:
  - Prescaler counts 0..TICK_DIV-1; tick=1 in the cycle it equals TICK_DIV-1.
  - On tick: seconds increment. Carry ripples into minutes, then hours, in the same cycle. 23:59:59 wraps to 00:00:00.
- Set FSM:
  - Each set rising edge (set=1 now, 0 previous cycle) advances RUN->SET_H->SET_M->SET_S->RUN.
  - In any SET state the prescaler is held at 0, tick=0 and time is frozen.
  - On SET_S->RUN the prescaler restarts from 0, so the first tick comes TICK_DIV cycles later.
- Up/down step, SET states only; up/down are ignored in RUN:
  - A rising edge of exactly one of up/down produces an immediate step on the selected field.
  - Steps wrap within that field only, with no carry: hour 23+1=0, 0-1=23; min/sec 59+1=0, 0-1=59.
  - Held button: after REPEAT_DELAY cycles of continuous hold, one step, then one step every REPEAT_RATE cycles while held.
  - up and down both high: no step, and the repeat counter is cleared.
  - Release clears the repeat counter.
  - A set edge in the same cycle as an up/down edge: the FSM advances and the step is discarded. The repeat counter is cleared on every state change.
- Blink:
  - Blink counter runs in all states. A phase bit toggles every BLINK_DIV cycles; the phase resets to "visible" on every state change.
  - In a SET state, while the phase is "hidden", both digits of the selected field output 7'h7F (blank). Other fields are unaffected.
- 12-hour mode:
  - Displayed hour = internal hour mod 12, with 0 shown as 12. pm = (hour >= 12).
  - A leading-zero tens digit is still shown as "0".
  - mode12 changes the display only and never alters stored time.
- Encoding: binary-to-two-digit BCD split per field, then the standard 0-9 active-low decoder. Non-BCD values cannot occur.
- Reset asserted mid-edit returns to RUN at 00:00:00 immediately.

Test Plan:
- TICK_DIV=4, reset pulse low then release, run 40 cycles -> tick every 4th cycle; seconds reach 10; disp0=7'b1000000 ("0"), disp1=7'b1111001 ("1").
- Preload via the set path to 23:59:58 with TICK_DIV=4, then run 8 cycles -> 00:00:00; pm falls 1->0; all displays show "0".
- Three set edges, then up pulsed in SET_S at seconds=59 -> seconds=0, minutes unchanged; a fourth set edge -> state=0 and the next tick comes exactly 4 cycles later.
- SET_H, REPEAT_DELAY=5, REPEAT_RATE=2, up held 12 cycles from hour 22 -> steps at edge, +5, +7, +9, +11 cycles; hour 22->23->0->1->2->3.
- SET_M with up and down both high for 20 cycles -> minutes unchanged. Separately, set and up rising in the same cycle -> state advances and no step occurs.
- mode12=1 at internal 00:xx and at 13:xx -> disp5/disp4 show "1","2" with pm=0, then "0","1" with pm=1. With BLINK_DIV=3 in SET_H, disp4/disp5 alternate 7'h7F every 3 cycles while disp0..disp3 stay steady.
